// File: rtl/lcd_host_seq.sv
// lcd_host_seq: host-side command sequencer for the 6x6 LCD window controller.
// Issues one command per request, streams 36 pixels on LOAD, and captures the 9-pixel window plus its sum.
// Ports:
//   clk, reset          - clock and async active-high reset
//   req_valid/_cmd/_ready - upstream request handshake (cmd 0..5 legal)
//   pix_addr, pix_data  - pixel store read port (combinational data)
//   cmd, cmd_valid, datain - command and pixel stream to the controller
//   lcd_busy, lcd_dataout, lcd_output_valid - controller status and window pixels
//   win_data, win_sum, win_valid - captured window, its sum, update pulse
//   err                 - pulse on illegal command or timeout
// Optional: define LCD_HOST_TIMEOUT_EN to add the TIMEOUT_CYC watchdog.
module lcd_host_seq
`ifdef LCD_HOST_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYC = 64
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_cmd,
  output logic        req_ready,
  output logic [5:0]  pix_addr,
  input  logic [7:0]  pix_data,
  output logic [2:0]  cmd,
  output logic        cmd_valid,
  output logic [7:0]  datain,
  input  logic        lcd_busy,
  input  logic [7:0]  lcd_dataout,
  input  logic        lcd_output_valid,
  output logic [71:0] win_data,
  output logic [11:0] win_sum,
  output logic        win_valid,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_LOAD,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [2:0]  cmd_q;
  logic        cmd_valid_q;
  logic [5:0]  pix_addr_q;
  logic [3:0]  beat_q;
  logic [71:0] buf_q;
  logic [71:0] buf_d;
  logic [11:0] sum_q;
  logic [11:0] sum_d;
  logic [71:0] win_data_q;
  logic [11:0] win_sum_q;
  logic        win_valid_q;
  logic        err_q;
  logic        tmo;
  logic        accept;

  // ISSUE completes on the first edge the controller is idle.
  assign accept = (state_q == S_ISSUE) && !lcd_busy;

  // Window buffer with the current beat's pixel merged in.
  always_comb begin
    buf_d = buf_q;
    for (int k = 0; k < 9; k++) begin
      if (beat_q == 4'(k)) buf_d[8*k +: 8] = lcd_dataout;
    end
    sum_d = sum_q + {4'd0, lcd_dataout};
  end

`ifdef LCD_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmr_q;

  // Counts cycles since acceptance; saturates at TIMEOUT_CYC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_q <= '0;
    end else if (accept) begin
      tmr_q <= TW'(1);
    end else if (tmr_q != TW'(TIMEOUT_CYC)) begin
      tmr_q <= tmr_q + TW'(1);
    end
  end

  // A normal DONE->IDLE exit on the last allowed cycle wins over the timeout.
  assign tmo = (state_q inside {S_LOAD, S_COLLECT, S_DONE})
            && (tmr_q == TW'(TIMEOUT_CYC))
            && !((state_q == S_DONE) && !lcd_busy);
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      pix_addr_q  <= '0;
      beat_q      <= '0;
      buf_q       <= '0;
      sum_q       <= '0;
      win_data_q  <= '0;
      win_sum_q   <= '0;
      win_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      win_valid_q <= 1'b0;
      err_q       <= 1'b0;
      if (tmo) begin
        state_q <= S_IDLE;
        err_q   <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (req_valid) begin
              if (req_cmd > 3'd5) begin
                err_q <= 1'b1;
              end else begin
                cmd_q       <= req_cmd;
                cmd_valid_q <= 1'b1;
                state_q     <= S_ISSUE;
              end
            end
          end
          S_ISSUE: begin
            if (!lcd_busy) begin
              cmd_valid_q <= 1'b0;
              pix_addr_q  <= '0;
              beat_q      <= '0;
              sum_q       <= '0;
              state_q     <= (cmd_q == 3'd1) ? S_LOAD : S_COLLECT;
            end
          end
          S_LOAD: begin
            if (pix_addr_q == 6'd35) begin
              state_q <= S_COLLECT;
            end else begin
              pix_addr_q <= pix_addr_q + 6'd1;
            end
          end
          S_COLLECT: begin
            if (lcd_output_valid) begin
              buf_q  <= buf_d;
              sum_q  <= sum_d;
              beat_q <= beat_q + 4'd1;
              if (beat_q == 4'd8) begin
                win_data_q  <= buf_d;
                win_sum_q   <= sum_d;
                win_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end
            end
          end
          S_DONE: begin
            if (!lcd_busy) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign pix_addr  = pix_addr_q;
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign datain    = (state_q == S_LOAD) ? pix_data : 8'd0;
  assign win_data  = win_data_q;
  assign win_sum   = win_sum_q;
  assign win_valid = win_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lcd_host_seq.sv
// tb_lcd_host_seq: directed bench for lcd_host_seq with a behavioural
// 6x6 window controller stub and a pixel store holding store[i] = i.
module tb_lcd_host_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_cmd = 3'd0;
  logic        req_ready;
  logic [5:0]  pix_addr;
  logic [7:0]  pix_data;
  logic [2:0]  cmd;
  logic        cmd_valid;
  logic [7:0]  datain;
  logic        lcd_busy = 1'b0;
  logic [7:0]  lcd_dataout = 8'd0;
  logic        lcd_output_valid = 1'b0;
  logic [71:0] win_data;
  logic [11:0] win_sum;
  logic        win_valid;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign pix_data = {2'b00, pix_addr};

  lcd_host_seq dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_cmd          (req_cmd),
    .req_ready        (req_ready),
    .pix_addr         (pix_addr),
    .pix_data         (pix_data),
    .cmd              (cmd),
    .cmd_valid        (cmd_valid),
    .datain           (datain),
    .lcd_busy         (lcd_busy),
    .lcd_dataout      (lcd_dataout),
    .lcd_output_valid (lcd_output_valid),
    .win_data         (win_data),
    .win_sum          (win_sum),
    .win_valid        (win_valid),
    .err              (err)
  );

  // Controller stub: acts on the falling edge, so everything it drives
  // is stable for the following rising edge.
  int         sph = 0;
  bit         go = 0;
  logic [2:0] scmd = 3'd0;
  int         cnt = 0;
  int         k = 0;
  int         dly = 0;
  int         tail = 0;
  int         wx = 0;
  int         wy = 0;
  logic [7:0] img [36];
  bit         hold_busy = 0;
  bit         hang = 0;
  int         n_acc = 0;

  always @(negedge clk) begin
    if (reset) begin
      sph = 0;
      go = 0;
      lcd_busy = 1'b0;
      lcd_output_valid = 1'b0;
      lcd_dataout = 8'd0;
    end else if (go) begin
      go = 0;
      n_acc++;
      lcd_busy = 1'b1;
      if (hang) begin
        sph = 4;
      end else if (scmd == 3'd1) begin
        img[0] = datain;
        cnt = 1;
        sph = 1;
      end else begin
        dly = 0;
        case (scmd)
          3'd2: if (wx < 3) begin wx++; dly = 1; end
          3'd3: if (wx > 0) begin wx--; dly = 1; end
          3'd4: if (wy > 0) begin wy--; dly = 1; end
          3'd5: if (wy < 3) begin wy++; dly = 1; end
          default: ;
        endcase
        k = 0;
        sph = 2;
      end
    end else begin
      case (sph)
        0: begin
          lcd_busy = hold_busy;
          if (cmd_valid && !lcd_busy) begin
            go = 1;
            scmd = cmd;
          end
        end
        1: begin
          img[cnt] = datain;
          cnt++;
          if (cnt == 36) begin
            wx = 0;
            wy = 3;
            k = 0;
            dly = 0;
            sph = 2;
          end
        end
        2: begin
          if (dly > 0) begin
            dly--;
            lcd_output_valid = 1'b0;
          end else if (k < 9) begin
            lcd_output_valid = 1'b1;
            lcd_dataout = img[(wy + k / 3) * 6 + wx + k % 3];
            k++;
          end else begin
            lcd_output_valid = 1'b0;
            tail = 2;
            sph = 3;
          end
        end
        3: begin
          if (tail > 0) tail--;
          else begin
            lcd_busy = 1'b0;
            sph = 0;
          end
        end
        default: ;
      endcase
    end
  end

  int wv_cnt = 0;
  int err_cnt = 0;
  int cv_cnt = 0;
  logic [71:0] last_wd = '0;
  logic [11:0] last_ws = '0;

  always @(negedge clk) begin
    if (win_valid) begin
      wv_cnt++;
      last_wd = win_data;
      last_ws = win_sum;
    end
    if (err) err_cnt++;
    if (cmd_valid) cv_cnt++;
  end

  // Window whose top-left pixel index is t, for an image with store[i] = i.
  function automatic logic [71:0] exp_wd(input int t);
    logic [71:0] r;
    r = '0;
    for (int j = 0; j < 9; j++) r[8*j +: 8] = 8'(t + (j / 3) * 6 + j % 3);
    return r;
  endfunction

  task automatic send(input logic [2:0] c, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      req_valid = 1'b1;
      req_cmd = c;
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic run_cmd(input logic [2:0] c, output bit ok);
    int w0;
    bit got;
    w0 = wv_cnt;
    send(c, ok);
    got = 0;
    for (int i = 0; i < 300 && ok; i++) begin
      @(negedge clk);
      if (wv_cnt > w0) begin
        got = 1;
        break;
      end
    end
    ok = ok && got;
    got = 0;
    for (int i = 0; i < 50 && ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1;
        break;
      end
    end
    ok = ok && got;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if ({req_ready, cmd_valid, win_valid, err} !== 4'b1000) begin n_fail++; $display("FAIL rst_ctrl: got %b want 1000", {req_ready, cmd_valid, win_valid, err}); end
    n_chk++; if (pix_addr !== 6'd0) begin n_fail++; $display("FAIL rst_pix_addr: got %0d want 0", pix_addr); end
    n_chk++; if (cmd !== 3'd0) begin n_fail++; $display("FAIL rst_cmd: got %0d want 0", cmd); end
    n_chk++; if (win_data !== 72'd0) begin n_fail++; $display("FAIL rst_win_data: got %h want 0", win_data); end
    n_chk++; if (win_sum !== 12'd0) begin n_fail++; $display("FAIL rst_win_sum: got %0d want 0", win_sum); end
    n_chk++; if (datain !== 8'd0) begin n_fail++; $display("FAIL rst_datain: got %0d want 0", datain); end
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if ({req_ready, cmd_valid} !== 2'b10) begin n_fail++; $display("FAIL idle_after_rst: got %b want 10", {req_ready, cmd_valid}); end
  endtask

  task automatic test_load;
    bit ok;
    int bad;
    int w0;
    int a0;
    for (int i = 0; i < 36; i++) img[i] = 8'hff;
    w0 = wv_cnt;
    a0 = n_acc;
    run_cmd(3'd1, ok);
    bad = 0;
    for (int i = 0; i < 36; i++) if (img[i] !== 8'(i)) bad++;
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL load_done: got %0d want 1", ok); end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL load_stream: got %0d bad beats want 0", bad); end
    n_chk++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL load_accepts: got %0d want 1", n_acc - a0); end
    n_chk++; if (last_wd !== 72'h20_1f_1e_1a_19_18_14_13_12) begin n_fail++; $display("FAIL load_win_data: got %h want 201f1e1a1918141312", last_wd); end
    n_chk++; if (last_ws !== 12'd225) begin n_fail++; $display("FAIL load_win_sum: got %0d want 225", last_ws); end
    n_chk++; if (wv_cnt - w0 !== 1) begin n_fail++; $display("FAIL load_win_valid: got %0d pulses want 1", wv_cnt - w0); end
    n_chk++; if (win_data !== 72'h20_1f_1e_1a_19_18_14_13_12) begin n_fail++; $display("FAIL load_win_hold: got %h", win_data); end
  endtask

  task automatic test_shift;
    logic [2:0] cl [11];
    int tl [11];
    int sm [11];
    bit ok;
    int w0;
    cl = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd4, 3'd4, 3'd4, 3'd4, 3'd3, 3'd5, 3'd0};
    tl = '{19, 20, 21, 21, 15, 9, 3, 3, 2, 8, 8};
    sm = '{234, 243, 252, 252, 198, 144, 90, 90, 81, 135, 135};
    for (int i = 0; i < 11; i++) begin
      w0 = wv_cnt;
      run_cmd(cl[i], ok);
      n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL shift_done[%0d]: got %0d want 1", i, ok); end
      n_chk++; if (last_wd !== exp_wd(tl[i])) begin n_fail++; $display("FAIL shift_win_data[%0d]: got %h want %h", i, last_wd, exp_wd(tl[i])); end
      n_chk++; if (last_ws !== 12'(sm[i])) begin n_fail++; $display("FAIL shift_win_sum[%0d]: got %0d want %0d", i, last_ws, sm[i]); end
      n_chk++; if (wv_cnt - w0 !== 1) begin n_fail++; $display("FAIL shift_win_valid[%0d]: got %0d want 1", i, wv_cnt - w0); end
    end
  endtask

  task automatic test_illegal;
    bit ok;
    bit rdy;
    int e0;
    int c0;
    int a0;
    for (int c = 6; c < 8; c++) begin
      e0 = err_cnt;
      c0 = cv_cnt;
      a0 = n_acc;
      send(3'(c), ok);
      rdy = 1;
      repeat (4) begin
        @(negedge clk);
        if (!req_ready) rdy = 0;
      end
      n_chk++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL illegal_err[%0d]: got %0d cycles want 1", c, err_cnt - e0); end
      n_chk++; if (cv_cnt - c0 !== 0) begin n_fail++; $display("FAIL illegal_cmd_valid[%0d]: got %0d cycles want 0", c, cv_cnt - c0); end
      n_chk++; if ((ok && rdy && (n_acc == a0)) !== 1'b1) begin n_fail++; $display("FAIL illegal_ready[%0d]: got ok=%0d rdy=%0d acc=%0d want 1 1 0", c, ok, rdy, n_acc - a0); end
    end
  endtask

  task automatic test_busy_hold;
    bit ok;
    bit held;
    bit got;
    int c0;
    int a0;
    int w0;
    hold_busy = 1;
    c0 = cv_cnt;
    a0 = n_acc;
    w0 = wv_cnt;
    send(3'd0, ok);
    held = 1;
    repeat (5) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd !== 3'd0) held = 0;
    end
    #2 hold_busy = 0;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wv_cnt > w0 && req_ready) begin
        got = 1;
        break;
      end
    end
    n_chk++; if ((ok && held) !== 1'b1) begin n_fail++; $display("FAIL busy_cmd_held: got %0d want 1", held); end
    n_chk++; if (cv_cnt - c0 < 6) begin n_fail++; $display("FAIL busy_cv_cycles: got %0d want >=6", cv_cnt - c0); end
    n_chk++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL busy_accepts: got %0d want 1", n_acc - a0); end
    n_chk++; if (got !== 1'b1) begin n_fail++; $display("FAIL busy_done: got %0d want 1", got); end
    n_chk++; if (last_ws !== 12'd135) begin n_fail++; $display("FAIL busy_win_sum: got %0d want 135", last_ws); end
  endtask

  task automatic test_reset_mid_load;
    bit ok;
    bit found;
    int bad;
    send(3'd1, ok);
    found = 0;
    for (int i = 0; i < 100 && ok; i++) begin
      @(negedge clk);
      if (pix_addr == 6'd17) begin
        found = 1;
        break;
      end
    end
    n_chk++; if ((found && datain == 8'd17) !== 1'b1) begin n_fail++; $display("FAIL mid_load_reach: got found=%0d datain=%0d want 1 17", found, datain); end
    #2 reset = 1'b1;
    #1;
    n_chk++; if ({pix_addr, cmd_valid, req_ready, datain} !== {6'd0, 1'b0, 1'b1, 8'd0}) begin n_fail++; $display("FAIL mid_rst_outs: got addr=%0d cv=%b rdy=%b din=%0d want 0 0 1 0", pix_addr, cmd_valid, req_ready, datain); end
    n_chk++; if ({win_data, win_sum} !== 84'd0) begin n_fail++; $display("FAIL mid_rst_win: got %h/%0d want 0/0", win_data, win_sum); end
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 36; i++) img[i] = 8'hff;
    run_cmd(3'd1, ok);
    bad = 0;
    for (int i = 0; i < 36; i++) if (img[i] !== 8'(i)) bad++;
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL reload_done: got %0d want 1", ok); end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL reload_stream: got %0d bad beats want 0", bad); end
    n_chk++; if (last_ws !== 12'd225) begin n_fail++; $display("FAIL reload_win_sum: got %0d want 225", last_ws); end
  endtask

`ifdef LCD_HOST_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    bit got;
    int n;
    int e0;
    int w0;
    logic [71:0] wd0;
    hang = 1;
    e0 = err_cnt;
    w0 = wv_cnt;
    wd0 = win_data;
    send(3'd0, ok);
    got = 0;
    n = 0;
    for (int i = 1; i < 150 && ok; i++) begin
      @(negedge clk);
      if (err_cnt > e0) begin
        got = 1;
        n = i;
        break;
      end
    end
    n_chk++; if ((got && n >= 60 && n <= 70) !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got seen=%0d at %0d want near 64", got, n); end
    n_chk++; if (wv_cnt - w0 !== 0) begin n_fail++; $display("FAIL timeout_win_valid: got %0d want 0", wv_cnt - w0); end
    n_chk++; if (win_data !== wd0) begin n_fail++; $display("FAIL timeout_win_kept: got %h want %h", win_data, wd0); end
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_idle: got %b want 1", req_ready); end
    hang = 0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_shift();
    test_illegal();
    test_busy_hold();
    test_reset_mid_load();
`ifdef LCD_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
